// File: rtl/io_read_decode_if.sv
// J1 IO bus as seen by an IO-mapped peripheral: address, write data, strobes and
// the registered read return.
interface io_read_decode_if #(
  parameter int DATA_WIDTH = 16
);
  logic [15:0]           cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_din;
  logic                  io_wr;
  logic                  io_rd;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_hit;

  modport master (
    output cpu_addr, cpu_din, io_wr, io_rd,
    input  rd_data, rd_hit
  );

  modport slave (
    input  cpu_addr, cpu_din, io_wr, io_rd,
    output rd_data, rd_hit
  );
endinterface

// File: rtl/io_read_decode_block.sv
// Read-side IO decode for the J1: ball X/Y shadows, vsync frame counter, sticky STATUS, ID.
// Define IORD_FRAME_IRQ_EN to add the IRQ_EN register at offset 5 and the frame interrupt.
module io_read_decode_block #(
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] BASE_ADDR  = 16'h0100,
  parameter bit          VS_POL     = 1'b0,
  parameter logic [15:0] ID_VALUE   = 16'h5047
) (
  input  logic              clk,
  input  logic              rst_n,
  io_read_decode_if.slave   bus,
  input  logic              vsync,
  input  logic              sprite_hit,
  output logic              irq
);

  typedef enum logic [2:0] {
    OFF_BALL_X    = 3'd0,
    OFF_BALL_Y    = 3'd1,
    OFF_FRAME_CNT = 3'd2,
    OFF_STATUS    = 3'd3,
    OFF_ID        = 3'd4,
    OFF_IRQ_EN    = 3'd5,
    OFF_RSVD6     = 3'd6,
    OFF_RSVD7     = 3'd7
  } reg_off_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic     in_win;
  reg_off_e off;
  logic     rd_en;
  logic     wr_en;

  assign in_win = (bus.cpu_addr[15:3] == BASE_ADDR[15:3]);
  assign off    = reg_off_e'(bus.cpu_addr[2:0] - BASE_ADDR[2:0]);
  assign rd_en  = bus.io_rd & in_win;
  assign wr_en  = bus.io_wr & in_win;

  // ---------------------------------------------------------------------------
  // Synchronizers and edge detectors for the asynchronous level inputs.
  // vsync is normalised to active-high first so both paths reset to "inactive".
  // ---------------------------------------------------------------------------
  logic       vs_act;
  logic [1:0] vs_sync;
  logic       vs_prev;
  logic [1:0] hit_sync;
  logic       hit_prev;
  logic       frame_edge;
  logic       hit_edge;

  assign vs_act = (vsync == VS_POL);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sync  <= '0;
      vs_prev  <= 1'b0;
      hit_sync <= '0;
      hit_prev <= 1'b0;
    end else begin
      vs_sync  <= {vs_sync[0], vs_act};
      vs_prev  <= vs_sync[1];
      hit_sync <= {hit_sync[0], sprite_hit};
      hit_prev <= hit_sync[1];
    end
  end

  assign frame_edge = vs_sync[1] & ~vs_prev;
  assign hit_edge   = hit_sync[1] & ~hit_prev;

  // ---------------------------------------------------------------------------
  // Shadow registers for the ball position writes
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] ball_x;
  logic [DATA_WIDTH-1:0] ball_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_x <= '0;
      ball_y <= '0;
    end else if (wr_en) begin
      if (off == OFF_BALL_X) ball_x <= bus.cpu_din;
      if (off == OFF_BALL_Y) ball_y <= bus.cpu_din;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame counter: a clear-write beats a coincident frame edge
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] frame_cnt;
  logic                  cnt_clr;

  assign cnt_clr = wr_en && (off == OFF_FRAME_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (cnt_clr) begin
      frame_cnt <= '0;
    end else if (frame_edge) begin
      frame_cnt <= frame_cnt + DATA_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky STATUS flags: cleared by a STATUS read, but a same-cycle set wins
  // ---------------------------------------------------------------------------
  logic frame_flag;
  logic hit_flag;
  logic frame_ovf;
  logic status_clr;

  assign status_clr = rd_en && (off == OFF_STATUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_flag <= 1'b0;
      hit_flag   <= 1'b0;
      frame_ovf  <= 1'b0;
    end else begin
      if (frame_edge)      frame_flag <= 1'b1;
      else if (status_clr) frame_flag <= 1'b0;

      if (frame_edge && frame_flag) frame_ovf <= 1'b1;
      else if (status_clr)          frame_ovf <= 1'b0;

      if (hit_edge)        hit_flag <= 1'b1;
      else if (status_clr) hit_flag <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional frame interrupt
  // ---------------------------------------------------------------------------
  logic irq_en;

`ifdef IORD_FRAME_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
    end else if (wr_en && (off == OFF_IRQ_EN)) begin
      irq_en <= bus.cpu_din[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en & frame_flag;
    end
  end

  assign irq = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux and registered read return
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_mux;

  // NOTE: the default assignment up front keeps this block purely combinational (no latch).
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_BALL_X:    rd_mux = ball_x;
      OFF_BALL_Y:    rd_mux = ball_y;
      OFF_FRAME_CNT: rd_mux = frame_cnt;
      OFF_STATUS:    rd_mux = {{(DATA_WIDTH-3){1'b0}}, frame_ovf, hit_flag, frame_flag};
      OFF_ID:        rd_mux = DATA_WIDTH'(ID_VALUE);
      OFF_IRQ_EN:    rd_mux = {{(DATA_WIDTH-1){1'b0}}, irq_en};
      default:       rd_mux = '0;
    endcase
  end

  // Outputs hold until the next io_rd; the mux sees pre-write state on a read+write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rd_data <= '0;
      bus.rd_hit  <= 1'b0;
    end else if (bus.io_rd) begin
      bus.rd_hit  <= in_win;
      bus.rd_data <= in_win ? rd_mux : '0;
    end
  end

endmodule
